pwm2_meas: RTL and testbench

Receive-side counterpart of the binary-weighted PWM generator. It recovers the 16-bit duty word by counting high cycles of the PWM line over one 2^W-cycle window. A binary-weighted frame of 2^W cycles spends exactly duty cycles high, so any contiguous 2^W-cycle window yields the duty word and no frame alignment is needed. Used for loopback self-test and for decoding PWM from external sources.

---
 rtl/pwm2_pkg.sv | 21 ++
 rtl/pwm_sync.sv | 28 ++
 rtl/pwm2_meas.sv | 126 ++++++++++++
 tb/tb_pwm2_meas.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm2_pkg.sv
// Shared types and helpers for the binary-weighted PWM measurement block.
//   DUTY_W : default duty word width
//   state_e: measurement FSM state
//   sat_w  : clamp a value to the largest w-bit unsigned number
package pwm2_pkg;

  localparam int unsigned DUTY_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clamp value to 2^w-1; valid for w < 32.
  function automatic logic [31:0] sat_w(input logic [31:0] value, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (value > max_v) ? max_v : value;
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset, clears the chain
//   d_i     : asynchronous input
//   q_o     : synchronised output (last stage)
module pwm_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; runs every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm2_meas.sv
// Recovers the duty word of a binary-weighted PWM line by counting high
// cycles over any contiguous 2^W-cycle window.
//   clock        : system clock
//   reset_n      : asynchronous active-low reset
//   enable       : 1 = measure, 0 = idle (partial window discarded)
//   restart      : abandon current window and start a new one
//   pwm_in       : PWM line, asynchronous to clock
//   duty_out     : last completed measurement
//   duty_valid   : one-cycle pulse when duty_out updates
//   duty_changed : pulse with duty_valid when the locked value changed
//   locked       : sticky, set after the first completed window
module pwm2_meas
  import pwm2_pkg::*;
#(
  parameter int unsigned W           = DUTY_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         restart,
  input  logic         pwm_in,
  output logic [W-1:0] duty_out,
  output logic         duty_valid,
  output logic         duty_changed,
  output logic         locked
);

  localparam int unsigned CNT_W = W + 1;
  localparam logic [W-1:0] WIN_LAST = '1;

  logic s;

  state_e         state_q,   state_d;
  logic [W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [W-1:0]   duty_q,    duty_d;
  logic           valid_q,   valid_d;
  logic           changed_q, changed_d;
  logic           locked_q,  locked_d;
  logic [W-1:0]   result_c;

  pwm_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (pwm_in),
    .q_o    (s)
  );

  // Final count includes the window-end sample; only a constant-high line reaches 2^W.
  assign result_c = W'(sat_w(32'(hi_cnt_q) + 32'(s), W));

  // Next-state, counters and output values.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    locked_d  = locked_q;
    case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        hi_cnt_d  = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          // Disable wins over restart and window end.
          state_d   = IDLE;
          win_cnt_d = '0;
          hi_cnt_d  = '0;
        end else if (restart) begin
          win_cnt_d = '0;
          hi_cnt_d  = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          // Window end: publish and roll straight into the next window.
          win_cnt_d = '0;
          hi_cnt_d  = '0;
          duty_d    = result_c;
          valid_d   = 1'b1;
          changed_d = locked_q && (result_c != duty_q);
          locked_d  = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q + W'(1);
          hi_cnt_d  = hi_cnt_q + CNT_W'(s);
        end
      end
      default: begin
        state_d   = IDLE;
        win_cnt_d = '0;
        hi_cnt_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      locked_q  <= locked_d;
    end
  end

  assign duty_out     = duty_q;
  assign duty_valid   = valid_q;
  assign duty_changed = changed_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_pwm2_meas.sv
// Scoreboard bench for pwm2_meas at W=4: expected measurements are queued
// when stimulus is set up and compared when duty_valid pulses.
module tb_pwm2_meas;

  localparam int unsigned TW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic          pwm_in = 1'b0;
  logic [TW-1:0] duty_out;
  logic          duty_valid;
  logic          duty_changed;
  logic          locked;

  typedef struct {
    int lo;
    int hi;
    int chg;
    int at;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // 0: constant low, 1: constant high, 2: binary-weighted pattern of gen_duty
  int            gen_mode = 0;
  logic [TW-1:0] gen_duty = '0;
  logic [TW-1:0] gen_c = '0;

  pwm2_meas #(
    .W           (TW),
    .SYNC_STAGES (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .restart      (restart),
    .pwm_in       (pwm_in),
    .duty_out     (duty_out),
    .duty_valid   (duty_valid),
    .duty_changed (duty_changed),
    .locked       (locked)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  function automatic logic [TW-1:0] rev4(input logic [TW-1:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Reference PWM source: each 16-cycle frame is high for exactly gen_duty cycles.
  always @(negedge clock) begin
    gen_c = gen_c + 4'd1;
    case (gen_mode)
      0:       pwm_in = 1'b0;
      1:       pwm_in = 1'b1;
      default: pwm_in = (rev4(gen_c) < gen_duty);
    endcase
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic push(input int lo, input int hi, input int chg, input int at);
    exp_t e;
    e.lo = lo; e.hi = hi; e.chg = chg; e.at = at;
    sb_q.push_back(e);
  endtask

  task automatic start_run(output int tm);
    enable = 1'b1;
    tm = cyc;
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < budget) begin
      step(1);
      b++;
    end
    check_eq("scoreboard_drained", sb_q.size(), 0);
  endtask

  // Output monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && duty_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("valid_unexpected", int'(duty_valid), 0);
      end else begin
        e = sb_q.pop_front();
        if (e.lo == e.hi)
          check_eq("duty_out", int'(duty_out), e.lo);
        else
          check_eq("duty_out_in_range", int'(duty_out >= TW'(e.lo) && duty_out <= TW'(e.hi)), 1);
        check_eq("duty_changed", int'(duty_changed), e.chg);
        check_eq("locked_on_valid", int'(locked), 1);
        check_eq("valid_cycle", cyc, e.at);
      end
    end else if (reset_n && duty_changed === 1'b1) begin
      check_eq("changed_without_valid", int'(duty_changed), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tm;
    // Reset values
    #1;
    check_eq("rst_duty_out", int'(duty_out), 0);
    check_eq("rst_valid", int'(duty_valid), 0);
    check_eq("rst_changed", int'(duty_changed), 0);
    check_eq("rst_locked", int'(locked), 0);
    step(2);
    reset_n = 1'b1;

    // Loopback, steady duty
    gen_mode = 2; gen_duty = 4'hB;
    step(4);
    start_run(tm);
    push(11, 11, 0, tm + 17);
    push(11, 11, 0, tm + 33);
    drain(100);
    enable = 1'b0;

    // Duty switched mid-window: transitional value, then the new value
    gen_duty = 4'h1;
    step(3);
    start_run(tm);
    push(1, 1, 1, tm + 17);
    push(2, 14, 1, tm + 33);
    push(15, 15, 1, tm + 49);
    push(15, 15, 0, tm + 65);
    step(25);
    gen_duty = 4'hF;
    drain(100);
    enable = 1'b0;

    // Constant high saturates, constant low reads zero
    gen_mode = 1;
    step(3);
    start_run(tm);
    push(15, 15, 0, tm + 17);
    push(15, 15, 0, tm + 33);
    drain(100);
    enable = 1'b0;
    gen_mode = 0;
    step(3);
    start_run(tm);
    push(0, 0, 1, tm + 17);
    push(0, 0, 0, tm + 33);
    drain(100);
    enable = 1'b0;

    // Restart on the window-end cycle suppresses that valid
    gen_mode = 2; gen_duty = 4'h5;
    step(3);
    start_run(tm);
    push(5, 5, 1, tm + 33);
    step(16);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    drain(100);
    enable = 1'b0;

    // Enable dropped at win_cnt=9: window discarded, outputs held
    step(3);
    start_run(tm);
    step(10);
    enable = 1'b0;
    step(20);
    check_eq("hold_duty_out", int'(duty_out), 5);
    check_eq("hold_locked", int'(locked), 1);
    check_eq("hold_valid", int'(duty_valid), 0);
    gen_duty = 4'h9;
    step(3);
    start_run(tm);
    push(9, 9, 1, tm + 17);
    drain(100);
    enable = 1'b0;

    // Reset mid-window
    step(3);
    start_run(tm);
    step(7);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_duty_out", int'(duty_out), 0);
    check_eq("midrst_valid", int'(duty_valid), 0);
    check_eq("midrst_changed", int'(duty_changed), 0);
    check_eq("midrst_locked", int'(locked), 0);
    enable = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(4);
    check_eq("postrst_duty_out", int'(duty_out), 0);
    check_eq("postrst_locked", int'(locked), 0);
    start_run(tm);
    push(9, 9, 0, tm + 17);
    drain(100);
    enable = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
